// File: rtl/vga_scan_gen_if.sv
// vga_scan_gen_if
// Pixel-side bundle of the VGA raster generator.
//   row, col     : current raster position, driven by the generator
//   pix_en       : one-clk pixel strobe, driven by the generator
//   color_in     : 12-bit {R,G,B} returned by the colour logic for row/col
//   vga_r/g/b    : registered, blanked colour at the board pins
//   hsync, vsync : registered sync at the board pins
//   frame_start  : one-clk pulse per frame
// master = generator side, slave = colour logic / observer side.
interface vga_scan_gen_if;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        pix_en;
    logic [11:0] color_in;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        output row, col, pix_en, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
        input  color_in
    );

    modport slave (
        input  row, col, pix_en, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
        output color_in
    );
endinterface

// File: rtl/vga_scan_gen.sv
// vga_scan_gen
// VGA raster generator. Divides clk into a pixel strobe, runs the horizontal
// and vertical counters, exposes row/col to the colour logic and registers
// blanked RGB plus hsync/vsync so that colour and sync stay aligned.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   vga   : vga_scan_gen_if.master (row, col, pix_en, color_in, vga_r/g/b,
//           hsync, vsync, frame_start)
module vga_scan_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_scan_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en_q;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic [11:0]      rgb_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             frame_start_q;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end

    // With CLK_DIV=1 div_cnt never leaves 0, so pix_en stays high after the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            pix_en_q <= (div_cnt == DIV_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en_q) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end
        end
    end

    // Output stage samples the pre-edge counters, so colour and sync lag the
    // counters by exactly one pixel period and stay aligned with each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en_q && h_wrap && v_wrap;
            if (pix_en_q) begin
                rgb_q   <= active ? vga.color_in : '0;
                hsync_q <= hs_raw ? SYNC_POL : ~SYNC_POL;
                vsync_q <= vs_raw ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.col         = h_cnt;
    assign vga.row         = (v_cnt < V_ACT) ? v_cnt[8:0] : '0;
    assign vga.vga_r       = rgb_q[11:8];
    assign vga.vga_g       = rgb_q[7:4];
    assign vga.vga_b       = rgb_q[3:0];
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame_start = frame_start_q;

endmodule
